// File: rtl/com_pkg.sv
// Shared definitions for the centre-of-mass divide sequencer.
//   com_state_t   : sequencer FSM states
//   COM_*         : default operand / output widths and watchdog limit
//   com_saturate  : clamp a quotient to the largest value an output field holds
package com_pkg;

  localparam int unsigned COM_WIDTH   = 29;
  localparam int unsigned COM_X_WIDTH = 8;
  localparam int unsigned COM_Y_WIDTH = 9;
  localparam int unsigned COM_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_X_ISSUE,
    ST_X_WAIT,
    ST_Y_ISSUE,
    ST_Y_WAIT,
    ST_DONE
  } com_state_t;

  // Returns quot unchanged if it fits in out_width bits, else all ones in
  // the low out_width bits. Caller truncates to the output width.
  function automatic logic [63:0] com_saturate(input logic [63:0] quot,
                                               input int unsigned out_width);
    logic [63:0] lim;
    lim = (64'd1 << out_width) - 64'd1;
    return (quot > lim) ? lim : quot;
  endfunction

endpackage

// File: rtl/com_div_sequencer_divider.sv
// divider: unsigned restoring divider, one quotient bit per cycle.
//   clk_in, rst_in (sync, active-high)
//   data_valid_in        : start request, accepted while not busy
//   dividend_in/divisor_in
//   quotient_out/remainder_out : valid while data_valid_out is high
//   data_valid_out       : one-cycle result pulse, WIDTH+1 cycles after the request
//   busy_out             : iterating, new requests are ignored
//   error_out            : divide by zero (pulses together with data_valid_out)
module divider #(
  parameter int unsigned WIDTH = 29
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             data_valid_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             data_valid_out,
  output logic             busy_out,
  output logic             error_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] div_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    ge    = (trial >= {1'b0, div_q});
    // Partial remainder stays below the divisor, so modulo-2^WIDTH is exact.
    diff  = trial[WIDTH-1:0] - div_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      quo_q          <= '0;
      rem_q          <= '0;
      div_q          <= '0;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      data_valid_out <= 1'b0;
      error_out      <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      error_out      <= 1'b0;
      if (busy_q) begin
        quo_q <= {quo_q[WIDTH-2:0], ge};
        rem_q <= ge ? diff : trial[WIDTH-1:0];
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          busy_q         <= 1'b0;
          data_valid_out <= 1'b1;
        end
      end else if (data_valid_in) begin
        if (divisor_in == '0) begin
          quo_q          <= '1;
          rem_q          <= dividend_in;
          data_valid_out <= 1'b1;
          error_out      <= 1'b1;
        end else begin
          quo_q  <= dividend_in;
          rem_q  <= '0;
          div_q  <= divisor_in;
          cnt_q  <= CNT_W'(WIDTH);
          busy_q <= 1'b1;
        end
      end
    end
  end

  assign quotient_out  = quo_q;
  assign remainder_out = rem_q;
  assign busy_out      = busy_q;

endmodule

// File: rtl/com_div_sequencer.sv
// com_div_sequencer: computes x/total and y/total for the centroid through a
// single shared divider, saturates each quotient to its output width and
// reports the pair with a one-cycle valid pulse (or an error pulse).
//   clk_in, rst_in (sync, active-low)
//   start_in                         : job request, taken only when ready_out
//   x_total_in, y_total_in, total_in : sums and pixel count
//   ready_out                        : idle, can accept start_in
//   x_out, y_out                     : last good centroid
//   valid_out / error_out            : one-cycle completion / failure pulse
module com_div_sequencer
  import com_pkg::*;
#(
  parameter int unsigned WIDTH       = COM_WIDTH,
  parameter int unsigned X_OUT_WIDTH = COM_X_WIDTH,
  parameter int unsigned Y_OUT_WIDTH = COM_Y_WIDTH,
  parameter int unsigned TIMEOUT     = COM_TIMEOUT
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic [WIDTH-1:0]       x_total_in,
  input  logic [WIDTH-1:0]       y_total_in,
  input  logic [WIDTH-1:0]       total_in,
  output logic                   ready_out,
  output logic [X_OUT_WIDTH-1:0] x_out,
  output logic [Y_OUT_WIDTH-1:0] y_out,
  output logic                   valid_out,
  output logic                   error_out
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  com_state_t state, state_nxt;

  logic [WIDTH-1:0]       x_total_q, y_total_q, total_q;
  logic [X_OUT_WIDTH-1:0] x_res_q;
  logic [Y_OUT_WIDTH-1:0] y_res_q;
  logic                   err_q;
  logic [WD_W-1:0]        wd_q;
  logic                   wd_expired;

  logic             div_rst;
  logic             div_start;
  logic             div_abort;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH-1:0] unused_div_rem;
  logic             div_valid;
  logic             div_busy;
  logic             div_err;

  assign wd_expired = (wd_q == WD_W'(TIMEOUT));

  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    div_start    = 1'b0;
    div_abort    = 1'b0;
    div_dividend = (state == ST_Y_ISSUE) ? y_total_q : x_total_q;
    unique case (state)
      ST_IDLE:
        if (start_in) state_nxt = (total_in == '0) ? ST_DONE : ST_X_ISSUE;
      ST_X_ISSUE: begin
        div_start = 1'b1;
        state_nxt = ST_X_WAIT;
      end
      ST_X_WAIT:
        if (div_valid) state_nxt = ST_Y_ISSUE;
        else if (wd_expired) begin
          div_abort = 1'b1;
          state_nxt = ST_DONE;
        end
      ST_Y_ISSUE: begin
        div_start = 1'b1;
        state_nxt = ST_Y_WAIT;
      end
      ST_Y_WAIT:
        if (div_valid) state_nxt = ST_DONE;
        else if (wd_expired) begin
          div_abort = 1'b1;
          state_nxt = ST_DONE;
        end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      x_total_q <= '0;
      y_total_q <= '0;
      total_q   <= '0;
      x_res_q   <= '0;
      y_res_q   <= '0;
      err_q     <= 1'b0;
      wd_q      <= '0;
      x_out     <= '0;
      y_out     <= '0;
      valid_out <= 1'b0;
      error_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      error_out <= 1'b0;
      // Counts only while waiting, so it restarts from zero in each WAIT.
      if (state == ST_X_WAIT || state == ST_Y_WAIT) wd_q <= wd_q + 1'b1;
      else                                          wd_q <= '0;
      unique case (state)
        ST_IDLE:
          if (start_in) begin
            x_total_q <= x_total_in;
            y_total_q <= y_total_in;
            total_q   <= total_in;
            err_q     <= (total_in == '0);
          end
        ST_X_WAIT:
          if (div_valid) begin
            x_res_q <= X_OUT_WIDTH'(com_saturate(64'(div_quot), X_OUT_WIDTH));
            if (div_err) err_q <= 1'b1;
          end else if (wd_expired) err_q <= 1'b1;
        ST_Y_WAIT:
          if (div_valid) begin
            y_res_q <= Y_OUT_WIDTH'(com_saturate(64'(div_quot), Y_OUT_WIDTH));
            if (div_err) err_q <= 1'b1;
          end else if (wd_expired) err_q <= 1'b1;
        ST_DONE: begin
          if (err_q) error_out <= 1'b1;
          else begin
            x_out     <= x_res_q;
            y_out     <= y_res_q;
            valid_out <= 1'b1;
          end
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ready_out = (state == ST_IDLE);
  assign div_rst   = !rst_in || div_abort;

  divider #(.WIDTH(WIDTH)) u_divider (
    .clk_in         (clk_in),
    .rst_in         (div_rst),
    .data_valid_in  (div_start),
    .dividend_in    (div_dividend),
    .divisor_in     (total_q),
    .quotient_out   (div_quot),
    .remainder_out  (unused_div_rem),
    .data_valid_out (div_valid),
    .busy_out       (div_busy),
    .error_out      (div_err)
  );

  a_issue_not_busy : assert property (@(posedge clk_in) disable iff (!rst_in)
    (state == ST_X_ISSUE || state == ST_Y_ISSUE) |-> !div_busy);

endmodule

// File: doc/com_div_sequencer.md
# com_div_sequencer

Sequencer that computes the centroid quotients for the center-of-mass path using one shared `divider` instance instead of two. It latches the accumulated x sum, y sum and pixel count on a start pulse, then issues the x and y divides back-to-back through the single divider. It saturates each quotient to the output coordinate width and presents the result as a single-cycle valid pulse. It sits between the per-frame accumulator and the consumer of the centroid (crosshair/overlay logic).

## Interface
- `WIDTH`, 29, operand width of sums, count and divider.
- `X_OUT_WIDTH`, 8, width of `x_out`.
- `Y_OUT_WIDTH`, 9, width of `y_out`.
- `TIMEOUT`, 64, maximum cycles spent in either WAIT state before abort.
- `clk_in` input 1: the single clock.
- `rst_in` input 1: synchronous, active-low reset.
- `start_in` input 1: request pulse; accepted only when `ready_out` is 1.
- `x_total_in` input WIDTH: sum of x coordinates.
- `y_total_in` input WIDTH: sum of y coordinates.
- `total_in` input WIDTH: pixel count (divisor).
- `ready_out` output 1: high only in IDLE.
- `x_out` output X_OUT_WIDTH: last good x centroid.
- `y_out` output Y_OUT_WIDTH: last good y centroid.
- `valid_out` output 1: one-cycle pulse when `x_out`/`y_out` update.
- `error_out` output 1: one-cycle pulse on a failed computation.

## Operation
- FSM states: IDLE, X_ISSUE, X_WAIT, Y_ISSUE, Y_WAIT, DONE.
- **IDLE:** `start_in`=1 latches the three operands.
  - If `total_in`==0, go to DONE with the error flag set. The divider is not used.
  - Otherwise go to X_ISSUE.
- **X_ISSUE / Y_ISSUE:**
  - Divider `data_valid_in` is driven combinationally high for exactly this one cycle.
  - Dividend is the latched x (resp. y) sum; divisor is the latched total.
  - Next state is the matching WAIT.
- **X_WAIT / Y_WAIT:**
  - Wait for divider `data_valid_out`, then capture its quotient.
  - Saturate: if quotient > 2^OUT_WIDTH−1, capture all ones; otherwise take the low bits.
  - Divider `error_out` sets the error flag.
  - X_WAIT goes to Y_ISSUE; Y_WAIT goes to DONE.
  - The watchdog counter clears on entry to each WAIT. Reaching TIMEOUT sets the error flag, asserts divider reset for one cycle, and goes to DONE.
- **DONE (one cycle):**
  - No error: register `x_out`, `y_out` and `valid_out`=1.
  - Error: register `error_out`=1; `x_out`/`y_out` hold their previous values.
  - Clear the error flag and go to IDLE.
- `start_in` outside IDLE is ignored: no queueing, no effect on the current job.
- `valid_out` and `error_out` are never high in the same cycle.
- Divider reset = (`rst_in`==0) OR watchdog abort, because the divider resets active-high.

## Timing
- Reset (`rst_in` low at a clock edge) forces:
  - state IDLE; `ready_out`=1;
  - `x_out`=0, `y_out`=0, `valid_out`=0, `error_out`=0;
  - watchdog and error flag cleared;
  - divider held in reset.
- Reset mid-operation abandons the job with no output pulse.
- Let D be the divider latency: the cycle `data_valid_in` is sampled to the cycle `data_valid_out` is high.
- With `start_in` sampled in cycle t:
  - X_ISSUE in t+1;
  - x result in t+1+D;
  - Y_ISSUE in t+2+D;
  - y result in t+2+2D;
  - DONE in t+3+2D;
  - `valid_out` high and `ready_out` high in t+4+2D.
- Zero divisor: DONE in t+1; `error_out` and `ready_out` high in t+2.
- Timeout: `error_out` is high 2 cycles after the watchdog reaches TIMEOUT.
- Throughput is one job per 2D+4 cycles. A new start is accepted in the same cycle `valid_out` is high.

## Structure
- Shared package `com_pkg`:
  - `com_state_t` enum (6 states);
  - `COM_WIDTH`=29, `COM_X_WIDTH`=8, `COM_Y_WIDTH`=9, `COM_TIMEOUT`=64.
- One sub-module: the existing `divider` (`WIDTH` passed through), instantiated once inside this block.
- `remainder_out` and `busy_out` are unused, except that `busy_out` feeds an assertion checking that it is low in ISSUE states.
- Saturation is a small function in `com_pkg`.

## Test plan
- **Normal:** x_total=1200, y_total=1600, total=10 → `x_out`=120, `y_out`=160, `valid_out` for exactly one cycle at t+2D+4, `error_out`=0.
- **Zero count:** total=0 after a good result of 120/160 → `error_out` pulse at t+2, `valid_out` stays 0, `x_out`/`y_out` stay 120/160.
- **Busy start:** second `start_in` (x_total=500, total=5) at t+3 → ignored; exactly one `valid_out`, carrying the first job's values.
- **Saturation:** x_total=3000, y_total=6000, total=10 → `x_out`=255, `y_out`=511.
- **Reset mid-job:** `rst_in` low for 1 cycle during X_WAIT → all outputs 0, `ready_out`=1, no pulse. The next job 1200/1600/10 gives 120/160.
- **Timeout:** TIMEOUT=8 with D>8 → `error_out` pulse, no `valid_out`, `ready_out` back high. The next job with TIMEOUT restored completes correctly.
